// File: rtl/hp_hud_addr_gen_pkg.sv
// Shared constants and types for the lives/health HUD sprite address generator.
// Sprite ROM holds six 96x32 frames, one per lives count, packed back to back.
package hp_hud_addr_gen_pkg;

    localparam int SPR_W       = 96;
    localparam int SPR_H       = 32;
    localparam int FRAME_WORDS = 3072;
    localparam int MAX_LIVES   = 5;
    localparam int ADDR_W      = 15;

    typedef enum logic {BLINK_IDLE, BLINK_ACTIVE} blink_state_t;

    function automatic logic [2:0] clamp_lives(input logic [2:0] lives);
        return (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
    endfunction

endpackage

// File: rtl/hp_hud_addr_gen_if.sv
// Beam, lives, sprite ROM and HUD pixel signals for hp_hud_addr_gen.
// master = video timing / ROM side, slave = the address generator.
import hp_hud_addr_gen_pkg::*;

interface hp_hud_addr_gen_if;
    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [2:0]        lives;
    logic [23:0]       rom_data;
    logic [ADDR_W-1:0] read_address;
    logic [23:0]       hud_rgb;
    logic              hud_on;

    modport master (
        output frame_start, DrawX, DrawY, lives, rom_data,
        input  read_address, hud_rgb, hud_on
    );

    modport slave (
        input  frame_start, DrawX, DrawY, lives, rom_data,
        output read_address, hud_rgb, hud_on
    );
endinterface

// File: rtl/hp_hud_addr_gen_blink_ctrl.sv
// Flashes the HUD for BLINK_FRAMES frames after a life is lost.
// Only instantiated when HUD_BLINK_EN is defined.
import hp_hud_addr_gen_pkg::*;

//  state        | meaning
//  BLINK_IDLE   | no recent life loss, sprite always shown
//  BLINK_ACTIVE | counting frames since the last loss, sprite toggles every BLINK_PERIOD frames
module hud_blink_ctrl #(
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [2:0] lives_q,
    input  logic [2:0] lives_next,
    output logic       show
);
    localparam int FCNT_W    = $clog2(BLINK_FRAMES);
    localparam int PHASE_BIT = $clog2(BLINK_PERIOD);

    blink_state_t      state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BLINK_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        show    = 1'b1;
        if (frame_start) begin
            if (lives_next < lives_q) begin
                state_d = BLINK_ACTIVE;
                fcnt_d  = '0;
            end else if (lives_next > lives_q) begin
                // game restart: stop flashing right away
                state_d = BLINK_IDLE;
                fcnt_d  = '0;
            end else if (state_q == BLINK_ACTIVE) begin
                if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                    state_d = BLINK_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
        if (state_q == BLINK_ACTIVE) begin
            show = ~fcnt_q[PHASE_BIT];
        end
    end
endmodule

// File: rtl/hp_hud_addr_gen.sv
// Beam-to-sprite-ROM address generator with 2-cycle pixel alignment for the lives HUD.
// Optional flashing after a life is lost is enabled by defining HUD_BLINK_EN.
import hp_hud_addr_gen_pkg::*;

module hp_hud_addr_gen #(
    parameter int HUD_X0       = 16,
    parameter int HUD_Y0       = 16,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    hp_hud_addr_gen_if.slave   bus
);
    logic [2:0]        lives_next;
    logic [2:0]        lives_q;
    logic [2:0]        lives_lost;
    logic [9:0]        dx, dy;
    logic              in_rgn;
    logic [ADDR_W-1:0] base, row_off, addr_next;
    logic [ADDR_W-1:0] read_address_q;
    logic              vis_d1, vis_d2;
    logic [23:0]       hud_rgb_q;
    logic              show;

    assign lives_next = clamp_lives(bus.lives);

    // Unsigned wrap makes pixels left of / above the sprite fail the compare.
    assign dx     = bus.DrawX - 10'(HUD_X0);
    assign dy     = bus.DrawY - 10'(HUD_Y0);
    assign in_rgn = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));

    // base = lives_lost*3072, row_off = dy*96, both as shift-adds
    assign lives_lost = 3'(MAX_LIVES) - lives_q;
    assign base       = (ADDR_W'(lives_lost) << 11) + (ADDR_W'(lives_lost) << 10);
    assign row_off    = (ADDR_W'(dy) << 6) + (ADDR_W'(dy) << 5);
    assign addr_next  = in_rgn ? (base + row_off + ADDR_W'(dx)) : base;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lives_q        <= 3'(MAX_LIVES);
            read_address_q <= '0;
            vis_d1         <= 1'b0;
            vis_d2         <= 1'b0;
            hud_rgb_q      <= '0;
        end else begin
            if (bus.frame_start) begin
                lives_q <= lives_next;
            end
            read_address_q <= addr_next;
            vis_d1         <= in_rgn;
            vis_d2         <= vis_d1;
            hud_rgb_q      <= vis_d1 ? bus.rom_data : '0;
        end
    end

`ifdef HUD_BLINK_EN
    hud_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_blink (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (bus.frame_start),
        .lives_q     (lives_q),
        .lives_next  (lives_next),
        .show        (show)
    );
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^{BLINK_FRAMES, BLINK_PERIOD};
    assign show             = 1'b1;
`endif

    assign bus.read_address = read_address_q;
    assign bus.hud_rgb      = hud_rgb_q;
    assign bus.hud_on       = vis_d2 && show;
endmodule
